// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage bit positions on the
// stall bus, the canonical stall vectors, controller states and the stall
// priority encoder.
package pipe_ctrl_pkg;

    // Bit position of each stage's hold signal on the stall bus
    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    // Each vector freezes every stage up to and including the requester, so
    // the register right after the requester sees stall[k] && !stall[k+1]
    // and turns into a bubble.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'((1 << (STAGE_IF + 1)) - 1);
    localparam logic [5:0] STALL_ID   = 6'((1 << (STAGE_ID + 1)) - 1);
    localparam logic [5:0] STALL_MEM  = 6'((1 << (STAGE_MEM + 1)) - 1);

    typedef enum logic {
        S_IDLE       = 1'b0,
        S_WAIT_FETCH = 1'b1
    } state_t;

    // Deepest requester wins: a MEM stall already covers ID and IF.
    function automatic logic [5:0] stall_select(
        input logic mem_req,
        input logic id_req,
        input logic fetch_req
    );
        if (mem_req)
            return STALL_MEM;
        else if (id_req)
            return STALL_ID;
        else if (fetch_req)
            return STALL_IF;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage RV32I core.
// Request paths are purely combinational; only the pending redirect target,
// the controller state and the two performance counters are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int STALL_WIDTH = 6,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_stall_req,
    input  logic                   id_stall_req,
    input  logic                   mem_stall_req,
    input  logic                   ex_jump_req,
    input  logic [ADDR_WIDTH-1:0]  ex_jump_target,
    output logic [STALL_WIDTH-1:0] stall_out,
    output logic                   jump_or_not,
    output logic                   redirect_valid,
    output logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [CNT_WIDTH-1:0]   flush_cnt,
    output logic [CNT_WIDTH-1:0]   stall_cnt
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] tgt_q;

    logic jump_acc;     // EX redirect taken this cycle (MEM not freezing EX)
    logic flush_act;    // wrong-path instructions present in IF/ID this cycle
    logic fire_now;     // redirect straight from EX, fetch is idle
    logic fire_pend;    // replay of a redirect parked behind a busy fetch

    // Saturating increment shared by both performance counters
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Decode requests against the current state into flush/redirect intents
    always_comb begin
        jump_acc  = (state == S_IDLE) && ex_jump_req && !mem_stall_req;
        fire_now  = jump_acc && !if_stall_req;
        fire_pend = (state == S_WAIT_FETCH) && !if_stall_req && !mem_stall_req;
        flush_act = jump_acc || (state == S_WAIT_FETCH);
    end

    // Drive the stall bus, flush and redirect; everything is held low in reset
    always_comb begin
        stall_out      = '0;
        jump_or_not    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (rst) begin
            // A load-use stall from ID is meaningless while ID holds a
            // wrong-path instruction that is about to be squashed.
            stall_out      = STALL_WIDTH'(stall_select(mem_stall_req,
                                                       id_stall_req && !flush_act,
                                                       if_stall_req));
            jump_or_not    = flush_act;
            redirect_valid = fire_now || fire_pend;
            if (fire_now)
                redirect_pc = ex_jump_target;
            else if (fire_pend)
                redirect_pc = tgt_q;
        end
    end

    // Controller FSM: park a redirect while a fetch is in flight, replay it later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            tgt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (jump_acc && if_stall_req) begin
                        tgt_q <= ex_jump_target;
                        state <= S_WAIT_FETCH;
                    end
                end
                S_WAIT_FETCH: begin
                    if (fire_pend)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Count accepted redirects; a replay does not count a second time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flush_cnt <= '0;
        else if (jump_acc)
            flush_cnt <= sat_inc(flush_cnt);
    end

    // Count cycles in which any stage is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (|stall_out)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with hand-computed pins, randomized
// traffic with occasional resets, and a long MEM stall for counter saturation.
// A single negedge process compares every output with a behavioural model.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int SW = 6;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_stall_req = 1'b0;
    logic          id_stall_req = 1'b0;
    logic          mem_stall_req = 1'b0;
    logic          ex_jump_req = 1'b0;
    logic [AW-1:0] ex_jump_target = '0;
    logic [SW-1:0] stall_out;
    logic          jump_or_not;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] stall_cnt;

    pipe_ctrl #(.ADDR_WIDTH(AW), .STALL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall_req   (if_stall_req),
        .id_stall_req   (id_stall_req),
        .mem_stall_req  (mem_stall_req),
        .ex_jump_req    (ex_jump_req),
        .ex_jump_target (ex_jump_target),
        .stall_out      (stall_out),
        .jump_or_not    (jump_or_not),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_cnt      (flush_cnt),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: a pending-redirect flag with its target and two
    // integer counters clamped at the counter maximum.
    bit          m_pend = 1'b0;
    logic [31:0] m_tgt  = '0;
    int          m_fc   = 0;
    int          m_sc   = 0;

    // Hand-computed pins set by the stimulus for the current cycle
    bit          pin_en = 1'b0;
    logic [5:0]  pin_stall;
    bit          pin_jon, pin_rv;
    logic [31:0] pin_pc;
    int          pin_fc, pin_sc;   // -1 means not pinned

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare process: check the DUT against the model, then advance the model
    always @(negedge clk) begin
        logic [5:0]  e_stall;
        bit          e_jon, e_rv, flushing, accept;
        logic [31:0] e_pc;
        e_stall = 6'b0; e_jon = 1'b0; e_rv = 1'b0; e_pc = '0;
        flushing = 1'b0; accept = 1'b0;
        if (!rst) begin
            m_pend = 1'b0; m_tgt = '0; m_fc = 0; m_sc = 0;
        end else begin
            accept   = !m_pend && ex_jump_req && !mem_stall_req;
            flushing = m_pend || accept;
            if (mem_stall_req)                    e_stall = 6'b011111;
            else if (id_stall_req && !flushing)   e_stall = 6'b000111;
            else if (if_stall_req)                e_stall = 6'b000011;
            e_jon = flushing;
            if (accept && !if_stall_req) begin
                e_rv = 1'b1; e_pc = ex_jump_target;
            end else if (m_pend && !if_stall_req && !mem_stall_req) begin
                e_rv = 1'b1; e_pc = m_tgt;
            end
        end
        cmp("stall_out",      32'(stall_out),      32'(e_stall));
        cmp("jump_or_not",    32'(jump_or_not),    32'(e_jon));
        cmp("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        cmp("redirect_pc",    redirect_pc,         e_pc);
        cmp("flush_cnt",      32'(flush_cnt),      32'(m_fc));
        cmp("stall_cnt",      32'(stall_cnt),      32'(m_sc));
        if (pin_en) begin
            cmp("pin_stall_out",   32'(stall_out),      32'(pin_stall));
            cmp("pin_jump_or_not", 32'(jump_or_not),    32'(pin_jon));
            cmp("pin_redirect_v",  32'(redirect_valid), 32'(pin_rv));
            cmp("pin_redirect_pc", redirect_pc,         pin_pc);
            if (pin_fc >= 0) cmp("pin_flush_cnt", 32'(flush_cnt), 32'(pin_fc));
            if (pin_sc >= 0) cmp("pin_stall_cnt", 32'(stall_cnt), 32'(pin_sc));
        end
        if (rst) begin
            if (accept) begin
                if (m_fc < CMAX) m_fc++;
                if (if_stall_req) begin
                    m_pend = 1'b1; m_tgt = ex_jump_target;
                end
            end else if (m_pend && !if_stall_req && !mem_stall_req) begin
                m_pend = 1'b0;
            end
            if (e_stall != 6'b0 && m_sc < CMAX) m_sc++;
        end
    end

    // Apply one cycle of inputs shortly after the rising edge
    task automatic cyc(input bit r, input bit fi, input bit di, input bit mi,
                       input bit ji, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r; if_stall_req = fi; id_stall_req = di; mem_stall_req = mi;
        ex_jump_req = ji; ex_jump_target = t;
        pin_en = 1'b0;
    endtask

    task automatic pin(input logic [5:0] s, input bit j, input bit v,
                       input logic [31:0] pc, input int fc, input int sc);
        pin_en = 1'b1; pin_stall = s; pin_jon = j; pin_rv = v; pin_pc = pc;
        pin_fc = fc; pin_sc = sc;
    endtask

    initial begin
        // Reset, then idle
        cyc(0, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 0, 0);
        // ID stall, then ID+MEM stall
        cyc(1, 0, 1, 0, 0, 0);                  pin(6'h07, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);                  pin(6'h1F, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 0, 2);
        // Immediate redirect with a simultaneous (ignored) ID stall
        cyc(1, 0, 1, 0, 1, 32'h0000_1040);      pin(6'h00, 1, 1, 32'h0000_1040, 0, 2);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 1, 2);
        // Redirect parked behind a 3-cycle fetch
        cyc(1, 1, 0, 0, 1, 32'h0000_2000);      pin(6'h03, 1, 0, 0, 1, 2);
        cyc(1, 1, 0, 0, 0, 0);                  pin(6'h03, 1, 0, 0, 2, 3);
        cyc(1, 1, 0, 0, 0, 0);                  pin(6'h03, 1, 0, 0, 2, 4);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 1, 1, 32'h0000_2000, 2, 5);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 2, 5);
        // Jump held pending under a 2-cycle MEM stall
        cyc(1, 0, 0, 1, 1, 32'h0000_3000);      pin(6'h1F, 0, 0, 0, 2, 5);
        cyc(1, 0, 0, 1, 1, 32'h0000_3000);      pin(6'h1F, 0, 0, 0, 2, 6);
        cyc(1, 0, 0, 0, 1, 32'h0000_3000);      pin(6'h00, 1, 1, 32'h0000_3000, 2, 7);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 3, 7);
        // Reset in WAIT_FETCH with requests active discards the redirect
        cyc(1, 1, 0, 0, 1, 32'h0000_4000);      pin(6'h03, 1, 0, 0, 3, 7);
        cyc(0, 1, 1, 1, 1, 32'h0000_5000);      pin(6'h00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 0, 0);

        // Randomized traffic with rare resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 2),
                ($urandom_range(0, 9) < 2),
                ($urandom_range(0, 3) == 0),
                {$urandom_range(0, 65535), 14'h0, 2'b00});
        end

        // Saturation of stall_cnt: more than 2^16 stalled cycles
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++)
            cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 0, 65535);
        cyc(1, 0, 1, 0, 0, 0);                  pin(6'h07, 0, 0, 0, 0, 65535);
        cyc(1, 0, 0, 0, 0, 0);                  pin(6'h00, 0, 0, 0, 0, 65535);
        @(posedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RV32I core. It collects stall requests from IF, ID and MEM and the taken-branch/jump request from EX. It drives the shared stall bus and the jump_or_not flush consumed by every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB). It also drives the PC redirect to the fetch stage. Redirects that arrive while an instruction fetch is still in flight are latched and replayed.

Parameters:
ADDR_WIDTH, 32, width of PC and redirect target
STALL_WIDTH, 6, stall bus width; bit0 PC, bit1 IF/IF_ID, bit2 ID/ID_EX, bit3 EX/EX_MEM, bit4 MEM/MEM_WB, bit5 WB
CNT_WIDTH, 16, width of the saturating performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
if_stall_req  in  1  fetch in flight or instruction memory busy
id_stall_req  in  1  load-use hazard detected in ID
mem_stall_req  in  1  load/store access in progress in MEM
ex_jump_req  in  1  EX resolved a taken branch or jump
ex_jump_target  in  ADDR_WIDTH  target of that branch or jump
stall_out  out  STALL_WIDTH  stall bus to PC and all pipeline registers
jump_or_not  out  1  flush; squashes IF_ID and ID_EX to bubbles at the next edge
redirect_valid  out  1  PC register loads redirect_pc at the next edge
redirect_pc  out  ADDR_WIDTH  redirect target
flush_cnt  out  CNT_WIDTH  count of accepted redirects, saturating
stall_cnt  out  CNT_WIDTH  count of cycles with stall_out != 0, saturating

Behaviour:
- Stall bus semantics, with downstream registers relying on them:
  - stall[k] && !stall[k+1]: the register after stage k inserts a bubble.
  - stall[k] && stall[k+1]: the register holds.
- stall_out is combinational from the requests and the current state, evaluated in priority order:
  - mem_stall_req: 6'b011111
  - else id_stall_req, accepted only when no flush is active this cycle: 6'b000111
  - else if_stall_req: 6'b000011
  - else 6'b000000
- A jump is accepted only when ex_jump_req && !mem_stall_req. While MEM stalls, EX is frozen and its request stays pending.
- id_stall_req is ignored in any cycle where jump_or_not=1, because the ID instruction is wrong-path.
- FSM states: IDLE, WAIT_FETCH.
  - IDLE, jump accepted, !if_stall_req:
    - jump_or_not=1, redirect_valid=1, redirect_pc=ex_jump_target, all combinational in the same cycle.
    - Stay in IDLE.
  - IDLE, jump accepted, if_stall_req:
    - jump_or_not=1, redirect_valid=0.
    - Latch ex_jump_target into tgt_q and go to WAIT_FETCH.
  - WAIT_FETCH:
    - jump_or_not=1 every cycle so the stale fetched instruction is squashed. ex_jump_req is ignored, since EX holds only bubbles.
    - If !if_stall_req && !mem_stall_req: redirect_valid=1, redirect_pc=tgt_q, then go to IDLE.
    - Otherwise remain in WAIT_FETCH with redirect_valid=0.
- redirect_pc=0 whenever redirect_valid=0.
- flush_cnt increments once per accepted jump, on the IDLE-state acceptance only.
- stall_cnt increments on every cycle with stall_out != 0.
- Both counters saturate at all-ones.
- Reset (asynchronous, rst=0):
  - state=IDLE, tgt_q=0, flush_cnt=0, stall_cnt=0.
  - Combinational outputs are forced to stall_out=0, jump_or_not=0, redirect_valid=0, redirect_pc=0 while rst=0.
  - Reset during WAIT_FETCH discards the pending redirect.
- No added latency on the request paths. Only tgt_q, the state and the counters are registered.

Decomposition:
- Shared Defines: the STALL_* stall-vector constants, the stage bit indices, and the state encodings S_IDLE/S_WAIT_FETCH.
- No sub-module; the saturating counters are inline.

Test Plan:
- Reset, then no requests: stall_out=0, jump_or_not=0, redirect_valid=0. Hold rst=0 mid-run with requests active: all outputs 0 and counters cleared immediately.
- id_stall_req=1 for 1 cycle: stall_out=6'b000111, so ID_EX sees a bubble. Same cycle with mem_stall_req=1: stall_out=6'b011111. stall_cnt increments by 1 per stalled cycle.
- ex_jump_req=1, target 32'h0000_1040, if_stall_req=0: same cycle jump_or_not=1, redirect_valid=1, redirect_pc=32'h0000_1040; flush_cnt 0->1. A simultaneous id_stall_req is ignored, so stall_out=0.
- ex_jump_req=1, target 32'h0000_2000, if_stall_req=1 for 3 cycles: jump_or_not=1 for 4 cycles. redirect_valid=0 for 3 cycles, then 1 with redirect_pc=32'h0000_2000 on the cycle if_stall_req drops. State returns to IDLE.
- ex_jump_req=1 with mem_stall_req=1 for 2 cycles: jump_or_not=0 and stall_out=6'b011111 during the stall. The redirect is accepted on the first cycle mem_stall_req=0.
- Force 2^16 stalled cycles: stall_cnt saturates at 16'hFFFF and does not wrap.
